vga_window_renderer: RTL and testbench
======================================

// Module: vga_window_renderer
// PURPOSE
//  Parametrised VGA display engine for the CNN result buffer. Generates its own
//  640x480 timing from clk via a pixel-tick divider. Reads a PIX_W-bit result
//  image from a synchronous BRAM port and paints it, optionally upscaled, into a
//  fixed window. The window is armed by the CNN done flag, shown from the next
//  frame boundary, and blanked again on request at a frame boundary.
// PARAMETERS
//  CLK_DIV     4    clk cycles per pixel tick (100 MHz -> 25 MHz)
//  H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48  horizontal timing in ticks (H_TOT=800)
//  V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33   vertical timing in lines (V_TOT=525)
//  WIN_X0      289  window left column (visible coords)
//  WIN_Y0      199  window top row
//  IMG_W       62   source image width in pixels
//  IMG_H       82   source image height in pixels
//  SCALE_LOG2  0    each source pixel drawn as 2^SCALE_LOG2 square screen pixels
//  PIX_W       1    bits per source pixel (1..8)
//  ADDR_W      13   buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
//  RD_LAT      1    BRAM read latency in clk; must be < CLK_DIV (elaboration check)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  src_done     in   1       level: result buffer complete and valid
//  src_clear    in   1       pulse: stop showing at next frame boundary
//  rd_en        out  1       buffer read enable
//  rd_addr      out  ADDR_W  buffer read address
//  rd_data      in   PIX_W   buffer data, valid RD_LAT clk after rd_en
//  hs, vs       out  1       sync, active low
//  r, g, b      out  4       colour (grey: r=g=b)
//  frame_start  out  1       1-clk pulse on last tick of each frame
//  showing      out  1       high while state==SHOW
// BEHAVIOUR
//  Reset: div/h/v counters=0, state=IDLE, hs=vs=1, r=g=b=0, rd_en=0, rd_addr=0,
//   frame_start=0. Reset mid-frame restarts timing at (0,0) on the next clk.
//  tick = (div==CLK_DIV-1); div wraps to 0. On tick, h increments; h==H_TOT-1
//   wraps to 0 and v increments; v==V_TOT-1 wraps to 0.
//  hs low for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); vs low for v in
//   [V_VIS+V_FP, +V_SYNC).
//  Frame boundary FB = tick & h==H_TOT-1 & v==V_TOT-1; frame_start=FB, registered.
//  FSM: IDLE -src_done-> ARMED; ARMED -FB-> SHOW; SHOW -src_clear seen-> latch
//   clr_pend; SHOW & clr_pend & FB -> IDLE. src_done has no effect in SHOW.
//   src_clear in ARMED returns to IDLE immediately. Never enter SHOW mid-frame.
//  in_win: WIN_X0 <= h < WIN_X0+(IMG_W<<S) and WIN_Y0 <= v < WIN_Y0+(IMG_H<<S),
//   with S=SCALE_LOG2, and h<H_VIS, v<V_VIS.
//  On tick with in_win & SHOW: rd_en=1 for one clk,
//   rd_addr=((v-WIN_Y0)>>S)*IMG_W + ((h-WIN_X0)>>S). Width is ADDR_W, with no
//   wrap in range. rd_en=0 otherwise.
//  Pipeline: hs, vs, in_win&SHOW and rd_data are sampled at RD_LAT clk after
//   the read. Outputs hs, vs, r, g, b for counter position (h,v) update on the
//   tick after (h,v). Total latency is exactly 1 pixel tick. hs/vs are delayed
//   identically to colour.
//  Colour: PIX_W=1 -> {4{d}}. PIX_W>=4 -> d[PIX_W-1:PIX_W-4]. PIX_W=2/3 -> MSBs
//   replicated to fill 4 bits (2'b10 -> 4'b1010). Outside the window, blanking,
//   or state!=SHOW -> 0.
// TESTING
//  1 Defaults, no src_done, run 2 frames -> hs low 96 ticks (384 clk) per 800-tick
//    line; vs low 2 lines per 525; r=g=b=0 and rd_en=0 throughout.
//  2 src_done at line 100 of frame 0 -> showing rises at frame_start ending frame 0;
//    window black in frame 0; reads begin at (289,199) in frame 1.
//  3 SHOW, rd_data=addr[0] -> addresses (289,199)=0, (350,199)=61,
//    (289,200)=62, (350,280)=5083; r=F/0 alternating, 1 tick after each read.
//  4 SCALE_LOG2=1, PIX_W=4 -> window 124x164; (291,201) gives addr 63;
//    rd_data=4'h9 gives r=g=b=9 on 2x2 screen pixels.
//  5 src_clear at v=300 while SHOW -> window drawn to end of frame, then showing=0;
//    next frame all black.
//  6 rst for 1 clk at (400,250) while SHOW -> outputs at reset values; next clk
//    h=v=0, state IDLE.

Source files
------------

// File: rtl/vga_window_renderer_if.sv
// Signal bundle between the VGA window renderer, its control source, result buffer and display.
interface vga_window_renderer_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned PIX_W  = 1
);
    logic              src_done;
    logic              src_clear;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              hs;
    logic              vs;
    logic [3:0]        r;
    logic [3:0]        g;
    logic [3:0]        b;
    logic              frame_start;
    logic              showing;

    modport master (
        input  src_done, src_clear, rd_data,
        output rd_en, rd_addr, hs, vs, r, g, b, frame_start, showing
    );

    modport slave (
        output src_done, src_clear, rd_data,
        input  rd_en, rd_addr, hs, vs, r, g, b, frame_start, showing
    );
endinterface

// File: rtl/vga_window_renderer.sv
// VGA timing generator that paints a buffered result image, optionally upscaled,
// into a fixed window; shown from a frame boundary after done, removed at a frame boundary after clear.
module vga_window_renderer #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned H_VIS      = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VIS      = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned WIN_X0     = 289,
    parameter int unsigned WIN_Y0     = 199,
    parameter int unsigned IMG_W      = 62,
    parameter int unsigned IMG_H      = 82,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned PIX_W      = 1,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    vga_window_renderer_if.master bus
);
    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_W   = $clog2(H_TOT);
    localparam int unsigned V_W   = $clog2(V_TOT);
    localparam int unsigned X_END = WIN_X0 + (IMG_W << SCALE_LOG2);
    localparam int unsigned Y_END = WIN_Y0 + (IMG_H << SCALE_LOG2);
    localparam int unsigned HS_LO = H_VIS + H_FP;
    localparam int unsigned HS_HI = HS_LO + H_SYNC;
    localparam int unsigned VS_LO = V_VIS + V_FP;
    localparam int unsigned VS_HI = VS_LO + V_SYNC;

    // Read data must land before the next pixel tick consumes it.
    if (RD_LAT < 1 || RD_LAT >= CLK_DIV) begin : g_lat_check
        $error("RD_LAT must lie in [1, CLK_DIV-1]");
    end
    if ((64'(1) << ADDR_W) < 64'(IMG_W * IMG_H)) begin : g_addr_check
        $error("ADDR_W too narrow for IMG_W*IMG_H");
    end

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHOW} state_e;

    state_e            state_q, state_d;
    logic              clr_pend_q, clr_pend_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [V_W-1:0]    v_q, v_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [RD_LAT-1:0] lat_q, lat_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              hs_p_q, hs_p_d, vs_p_q, vs_p_d, vis_p_q, vis_p_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    logic [3:0]        grey_q, grey_d;
    logic              frame_start_q, frame_start_d;
    logic              showing_q, showing_d;

    logic              tick, h_end, v_end, fb, in_win, show;
    logic [31:0]       hx, vy, row, col;
    logic [PIX_W-1:0]  pix_now;

    // Grey level: source MSBs repeated to fill four bits.
    function automatic logic [3:0] to_grey(input logic [PIX_W-1:0] d);
        logic [3:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            o[3-i] = d[PIX_W-1-(i % PIX_W)];
        end
        return o;
    endfunction

    always_comb begin
        state_d       = state_q;
        clr_pend_d    = clr_pend_q;
        div_d         = div_q;
        h_d           = h_q;
        v_d           = v_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        hs_p_d        = hs_p_q;
        vs_p_d        = vs_p_q;
        vis_p_d       = vis_p_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        grey_d        = grey_q;

        tick  = (div_q == DIV_W'(CLK_DIV - 1));
        h_end = (h_q == H_W'(H_TOT - 1));
        v_end = (v_q == V_W'(V_TOT - 1));
        fb    = tick & h_end & v_end;
        hx    = 32'(h_q);
        vy    = 32'(v_q);
        show  = (state_q == S_SHOW);

        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
            h_d = h_end ? '0 : h_q + H_W'(1);
            if (h_end) begin
                v_d = v_end ? '0 : v_q + V_W'(1);
            end
        end

        in_win = (hx >= WIN_X0) && (hx < X_END) && (vy >= WIN_Y0) && (vy < Y_END)
                 && (hx < H_VIS) && (vy < V_VIS);
        row = (vy - WIN_Y0) >> SCALE_LOG2;
        col = (hx - WIN_X0) >> SCALE_LOG2;

        // Window only ever switches on or off on a frame boundary.
        unique case (state_q)
            S_IDLE: begin
                clr_pend_d = 1'b0;
                if (bus.src_done) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.src_clear) state_d = S_IDLE;
                else if (fb)       state_d = S_SHOW;
            end
            S_SHOW: begin
                if (bus.src_clear) clr_pend_d = 1'b1;
                if (clr_pend_q && fb) begin
                    state_d    = S_IDLE;
                    clr_pend_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tick && in_win && show) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(row * IMG_W + col);
        end

        // Track the outstanding read so its data is captured exactly when valid.
        lat_d   = RD_LAT'({lat_q, rd_en_q});
        pix_now = lat_q[RD_LAT-1] ? bus.rd_data : pix_q;
        pix_d   = pix_now;

        // Two-stage tick pipeline: sample position now, present it on the next tick.
        if (tick) begin
            hs_p_d  = !((hx >= HS_LO) && (hx < HS_HI));
            vs_p_d  = !((vy >= VS_LO) && (vy < VS_HI));
            vis_p_d = in_win & show;
            hs_d    = hs_p_q;
            vs_d    = vs_p_q;
            grey_d  = vis_p_q ? to_grey(pix_now) : 4'h0;
        end

        frame_start_d = fb;
        showing_d     = (state_d == S_SHOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_pend_q    <= 1'b0;
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            lat_q         <= '0;
            pix_q         <= '0;
            hs_p_q        <= 1'b1;
            vs_p_q        <= 1'b1;
            vis_p_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            grey_q        <= 4'h0;
            frame_start_q <= 1'b0;
            showing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_pend_q    <= clr_pend_d;
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            lat_q         <= lat_d;
            pix_q         <= pix_d;
            hs_p_q        <= hs_p_d;
            vs_p_q        <= vs_p_d;
            vis_p_q       <= vis_p_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            grey_q        <= grey_d;
            frame_start_q <= frame_start_d;
            showing_q     <= showing_d;
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.r           = grey_q;
    assign bus.g           = grey_q;
    assign bus.b           = grey_q;
    assign bus.frame_start = frame_start_q;
    assign bus.showing     = showing_q;
endmodule

// File: tb/tb_vga_window_renderer.sv
// Bench for vga_window_renderer: two reduced-timing instances (1x/1-bit and 2x/4-bit)
// checked every clk against a frame/pixel-position model plus literal pins.
module tb_vga_window_renderer;
    localparam int CD = 4;
    localparam int HT = 28;
    localparam int VT = 16;
    localparam int FT = HT * VT;
    localparam int FC = FT * CD;
    localparam int LC = HT * CD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic src_done = 1'b0;
    logic src_clear = 1'b0;
    logic       mem_a = 1'b0;
    logic [3:0] st_b = 4'h0;
    logic [3:0] mem_b = 4'h0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    bit   shown [0:15];

    always #5 clk = ~clk;

    vga_window_renderer_if #(.ADDR_W(8), .PIX_W(1)) if_a ();
    vga_window_renderer_if #(.ADDR_W(8), .PIX_W(4)) if_b ();

    vga_window_renderer #(
        .CLK_DIV(CD), .H_VIS(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .WIN_X0(5), .WIN_Y0(3), .IMG_W(6), .IMG_H(4),
        .SCALE_LOG2(0), .PIX_W(1), .ADDR_W(8), .RD_LAT(1)
    ) u_a (.clk(clk), .rst(rst), .bus(if_a));

    vga_window_renderer #(
        .CLK_DIV(CD), .H_VIS(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .WIN_X0(5), .WIN_Y0(3), .IMG_W(6), .IMG_H(4),
        .SCALE_LOG2(1), .PIX_W(4), .ADDR_W(8), .RD_LAT(2)
    ) u_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.src_done  = src_done;
    assign if_a.src_clear = src_clear;
    assign if_b.src_done  = src_done;
    assign if_b.src_clear = src_clear;
    assign if_a.rd_data   = mem_a;
    assign if_b.rd_data   = mem_b;

    function automatic int f_b(input int addr);
        return (addr * 5 + 9) % 16;
    endfunction

    function automatic int exp_colour(input int s, input int addr);
        if (s == 0) return (addr % 2 == 1) ? 15 : 0;
        return f_b(addr);
    endfunction

    function automatic bit win(input int s, input int h, input int v);
        return (h >= 5) && (h < 5 + (6 << s)) && (v >= 3) && (v < 3 + (4 << s));
    endfunction

    function automatic int addr_of(input int s, input int h, input int v);
        return ((v - 3) >> s) * 6 + ((h - 5) >> s);
    endfunction

    // Buffer models: 1-clk and 2-clk read latency.
    always @(posedge clk) begin
        cyc <= rst ? 0 : cyc + 1;
        if (if_a.rd_en) mem_a <= if_a.rd_addr[0];
        if (if_b.rd_en) st_b <= 4'(f_b(int'(if_b.rd_addr)));
        mem_b <= st_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cyc %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) chk("wait_timeout", 32'(cyc), 32'(n));
    endtask

    task automatic chk_inst(input int s, input logic hs, input logic vs,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                            input logic rd_en, input logic [7:0] rd_addr,
                            input logic fs, input logic sh);
        int p, q, h, v, e_hs, e_vs, e_rgb, e_en;
        p = cyc / CD - 2;
        e_hs = 1; e_vs = 1; e_rgb = 0;
        if (p >= 0) begin
            h = p % HT;
            v = (p / HT) % VT;
            e_hs = (h >= 22 && h < 25) ? 0 : 1;
            e_vs = (v >= 13 && v < 15) ? 0 : 1;
            if (shown[(p / FT) % 16] && win(s, h, v)) e_rgb = exp_colour(s, addr_of(s, h, v));
        end
        chk(s == 0 ? "a_hs" : "b_hs", 32'(hs), 32'(e_hs));
        chk(s == 0 ? "a_vs" : "b_vs", 32'(vs), 32'(e_vs));
        chk(s == 0 ? "a_r" : "b_r", 32'(r), 32'(e_rgb));
        chk(s == 0 ? "a_g" : "b_g", 32'(g), 32'(e_rgb));
        chk(s == 0 ? "a_b" : "b_b", 32'(b), 32'(e_rgb));
        q = cyc / CD - 1;
        e_en = 0;
        if (cyc % CD == 0 && q >= 0) begin
            h = q % HT;
            v = (q / HT) % VT;
            if (shown[(q / FT) % 16] && win(s, h, v)) e_en = 1;
        end
        chk(s == 0 ? "a_rd_en" : "b_rd_en", 32'(rd_en), 32'(e_en));
        if (e_en == 1) chk(s == 0 ? "a_rd_addr" : "b_rd_addr", 32'(rd_addr), 32'(addr_of(s, h, v)));
        chk(s == 0 ? "a_frame_start" : "b_frame_start", 32'(fs), (cyc > 0 && cyc % FC == 0) ? 32'd1 : 32'd0);
        chk(s == 0 ? "a_showing" : "b_showing", 32'(sh), shown[(cyc / FC) % 16] ? 32'd1 : 32'd0);
    endtask

    // Per-clk model compare.
    always @(negedge clk) begin
        if (chk_en) begin
            chk_inst(0, if_a.hs, if_a.vs, if_a.r, if_a.g, if_a.b, if_a.rd_en, if_a.rd_addr,
                     if_a.frame_start, if_a.showing);
            chk_inst(1, if_b.hs, if_b.vs, if_b.r, if_b.g, if_b.b, if_b.rd_en, if_b.rd_addr,
                     if_b.frame_start, if_b.showing);
        end
    end

    task automatic chk_reset_state();
        chk("rst_hs", 32'(if_a.hs), 32'd1);
        chk("rst_vs", 32'(if_a.vs), 32'd1);
        chk("rst_r", 32'(if_a.r), 32'd0);
        chk("rst_rd_en", 32'(if_a.rd_en), 32'd0);
        chk("rst_rd_addr", 32'(if_a.rd_addr), 32'd0);
        chk("rst_showing", 32'(if_b.showing), 32'd0);
        chk("rst_frame_start", 32'(if_b.frame_start), 32'd0);
    endtask

    // Hand-computed pins on frame 0/1 timing and addresses.
    initial begin
        @(negedge clk);
        while (!chk_en) @(negedge clk);
        wait_cyc(96);   chk("pin_hs_low_start", 32'(if_a.hs), 32'd0);
        wait_cyc(107);  chk("pin_hs_low_last", 32'(if_a.hs), 32'd0);
        wait_cyc(108);  chk("pin_hs_high_after", 32'(if_a.hs), 32'd1);
        wait_cyc(360);  chk("pin_frame0_no_read", 32'(if_a.rd_en), 32'd0);
        wait_cyc(1464); chk("pin_vs_low", 32'(if_a.vs), 32'd0);
        wait_cyc(1791); chk("pin_showing_pre", 32'(if_a.showing), 32'd0);
        wait_cyc(1792); chk("pin_showing_rise", 32'(if_a.showing), 32'd1);
                        chk("pin_frame_start", 32'(if_a.frame_start), 32'd1);
        wait_cyc(2152); chk("pin_rd_en_5_3", 32'(if_a.rd_en), 32'd1);
                        chk("pin_addr_5_3", 32'(if_a.rd_addr), 32'd0);
        wait_cyc(2156); chk("pin_r_5_3", 32'(if_a.r), 32'd0);
        wait_cyc(2160); chk("pin_r_6_3", 32'(if_a.r), 32'd15);
        wait_cyc(2172); chk("pin_addr_10_3", 32'(if_a.rd_addr), 32'd5);
        wait_cyc(2264); chk("pin_addr_5_4", 32'(if_a.rd_addr), 32'd6);
        wait_cyc(2384); chk("pin_b_addr_7_5", 32'(if_b.rd_addr), 32'd7);
        wait_cyc(2388); chk("pin_b_r_7_5", 32'(if_b.r), 32'd12);
        wait_cyc(2508); chk("pin_addr_10_6", 32'(if_a.rd_addr), 32'd23);
    end

    initial begin
        for (int i = 0; i < 16; i++) shown[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        chk_en = 1'b1;

        wait_cyc(5 * LC);
        src_done = 1'b1;
        shown[1] = 1'b1; shown[2] = 1'b1; shown[3] = 1'b1;
        wait_cyc(2 * FC + 100);
        src_done = 1'b0;

        // Clear mid-frame 3: frame 3 completes, frame 4 blank.
        wait_cyc(3 * FC + 7 * LC);
        src_clear = 1'b1;
        wait_cyc(3 * FC + 7 * LC + 1);
        src_clear = 1'b0;

        // Clear while armed cancels the pending show.
        wait_cyc(5 * FC + 2 * LC);
        src_done = 1'b1;
        wait_cyc(5 * FC + 2 * LC + 1);
        src_done = 1'b0;
        wait_cyc(5 * FC + 4 * LC);
        src_clear = 1'b1;
        wait_cyc(5 * FC + 4 * LC + 1);
        src_clear = 1'b0;

        wait_cyc(6 * FC + LC);
        src_done = 1'b1;
        shown[7] = 1'b1;
        wait_cyc(6 * FC + LC + 1);
        src_done = 1'b0;

        // One-clk reset in the middle of a shown window.
        wait_cyc(7 * FC + 6 * LC + 40);
        chk("pin_pre_rst_showing", 32'(if_a.showing), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) shown[i] = 1'b0;
        chk("pin_post_rst_cyc", 32'(cyc), 32'd0);
        chk_reset_state();

        wait_cyc(FC + 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
